delay_ctrl: RTL

// - Upstream of the delay display stage: converts two raw push-buttons into the 14-bit echo delay word.
// - Delay is expressed in samples. It drives both the echo delay-line read offset and the display input.
// - Press-to-step behaviour, auto-repeat on hold, and saturation at 0 and MAX_DELAY.
// - Pressing both keys together restores DEF_DELAY.

---
 rtl/delay_pkg.sv | 42 ++++
 rtl/delay_ctrl_if.sv | 30 +++
 rtl/key_debounce.sv | 51 +++++
 rtl/delay_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// delay_pkg: shared definitions for the echo delay path.
//   DW         width of the delay word (samples)
//   MAX_DELAY  upper saturation limit of the delay word
//   DEF_DELAY  delay after reset and after a both-keys press
//   state_t    delay_ctrl FSM states
//   step_delay saturating one-step update of a delay word
// The display stage and the delay-line addressing use the same package,
// so the delay word has one width everywhere.
package delay_pkg;

  localparam int DW = 14;
  localparam logic [DW-1:0] MAX_DELAY = DW'(16383);
  localparam logic [DW-1:0] DEF_DELAY = DW'(4800);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP,
    ST_HOLD,
    ST_REPEAT,
    ST_BOTH
  } state_t;

  // The arithmetic is one bit wider than the delay word, so an up-step
  // near the top cannot wrap before it is clamped to MAX_DELAY.
  function automatic logic [DW-1:0] step_delay(input logic [DW-1:0] cur,
                                               input logic          up,
                                               input logic [DW:0]   step);
    logic [DW:0] wide;
    if (up) begin
      wide = {1'b0, cur} + step;
      if (wide > {1'b0, MAX_DELAY}) begin
        wide = {1'b0, MAX_DELAY};
      end
    end else if ({1'b0, cur} < step) begin
      wide = '0;
    end else begin
      wide = {1'b0, cur} - step;
    end
    return wide[DW-1:0];
  endfunction

endpackage

// File: rtl/delay_ctrl_if.sv
// delay_ctrl_if: button inputs and delay outputs of the delay controller.
//   key_up_n   raw "increase" button, active low, asynchronous
//   key_dn_n   raw "decrease" button, active low, asynchronous
//   delay      current delay in samples
//   delay_upd  one-cycle pulse when delay takes a new value
// master: the side that owns the buttons and consumes the delay.
// slave:  the delay controller itself.
interface delay_ctrl_if;
  import delay_pkg::*;

  logic          key_up_n;
  logic          key_dn_n;
  logic [DW-1:0] delay;
  logic          delay_upd;

  modport master (
    output key_up_n,
    output key_dn_n,
    input  delay,
    input  delay_upd
  );

  modport slave (
    input  key_up_n,
    input  key_dn_n,
    output delay,
    output delay_upd
  );

endinterface

// File: rtl/key_debounce.sv
// key_debounce: synchroniser plus debounce filter for one raw push-button.
//   CLOCK_50  system clock, rising edge
//   rst_n     synchronous reset, active low
//   raw_n     raw button, active low, asynchronous to CLOCK_50
//   clean     debounced level, active high (1 = pressed)
// The clean level follows the synchronised input only after DEB_CYCLES
// consecutive samples that differ from the current clean level; any sample
// equal to the current level reloads the counter. A raw edge reaches clean
// DEB_CYCLES+2 cycles later.
module key_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic rst_n,
  input  logic raw_n,
  output logic clean
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_n_reg;   // debounced level, still in raw polarity
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      // Reset to the released level so a key held through reset has to be
      // debounced again before it counts.
      sync1_reg   <= 1'b1;
      sync2_reg   <= 1'b1;
      level_n_reg <= 1'b1;
      cnt_reg     <= '0;
    end else begin
      sync1_reg <= raw_n;
      sync2_reg <= sync1_reg;
      if (sync2_reg == level_n_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        level_n_reg <= sync2_reg;
        cnt_reg     <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign clean = ~level_n_reg;

endmodule

// File: rtl/delay_ctrl.sv
// delay_ctrl: turns two raw push-buttons into the echo delay word.
//   CLOCK_50        system clock, rising edge
//   rst_n           synchronous reset, active low
//   bus.key_up_n    raw "increase" button (active low)
//   bus.key_dn_n    raw "decrease" button (active low)
//   bus.delay       current delay in samples (registered)
//   bus.delay_upd   one-cycle pulse together with each new delay value
// A press steps the delay once; holding it for HOLD_CYCLES starts
// auto-repeat with one step every RPT_CYCLES. Both keys together restore
// DEF_DELAY. Steps saturate at 0 and MAX_DELAY.
module delay_ctrl
  import delay_pkg::*;
#(
  parameter int DEB_CYCLES  = 500000,
  parameter int HOLD_CYCLES = 25000000,
  parameter int RPT_CYCLES  = 5000000,
  parameter int STEP        = 64
) (
  input  logic CLOCK_50,
  input  logic rst_n,
  delay_ctrl_if.slave bus
);

  // One counter serves both the hold phase and the repeat phase.
  localparam int CNT_MAX = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] RPT_LAST  = CW'(RPT_CYCLES - 1);
  localparam logic [DW:0]   STEP_W    = (DW+1)'(STEP);

  // Index 0 = up key, index 1 = down key.
  logic [1:0] raw_n_vec;
  logic [1:0] clean_vec;

  assign raw_n_vec = {bus.key_dn_n, bus.key_up_n};

  for (genvar gi = 0; gi < 2; gi++) begin : g_key
    key_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .CLOCK_50(CLOCK_50),
      .rst_n   (rst_n),
      .raw_n   (raw_n_vec[gi]),
      .clean   (clean_vec[gi])
    );
  end

  logic key_up;
  logic key_dn;
  assign key_up = clean_vec[0];
  assign key_dn = clean_vec[1];

  state_t        state_reg,  state_next;
  logic          dir_up_reg, dir_up_next;   // direction of the key being held
  logic [CW-1:0] cnt_reg,    cnt_next;
  logic [DW-1:0] delay_reg,  delay_next;
  logic          upd_reg;
  logic          do_step;
  logic          held;

  assign held = dir_up_reg ? key_up : key_dn;

  always_comb begin
    state_next  = state_reg;
    dir_up_next = dir_up_reg;
    cnt_next    = cnt_reg;
    delay_next  = delay_reg;
    do_step     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (key_up && key_dn) begin
          state_next = ST_BOTH;
        end else if (key_up || key_dn) begin
          state_next  = ST_STEP;
          dir_up_next = key_up;
        end
      end

      ST_STEP: begin
        do_step    = 1'b1;
        state_next = ST_HOLD;
        cnt_next   = '0;
      end

      ST_HOLD: begin
        if (key_up && key_dn) begin
          state_next = ST_BOTH;
        end else if (!held) begin
          state_next = ST_IDLE;
        end else if (cnt_reg == HOLD_LAST) begin
          do_step    = 1'b1;
          state_next = ST_REPEAT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      ST_REPEAT: begin
        if (key_up && key_dn) begin
          state_next = ST_BOTH;
        end else if (!held) begin
          state_next = ST_IDLE;
        end else if (cnt_reg == RPT_LAST) begin
          do_step  = 1'b1;
          cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      ST_BOTH: begin
        // Reloading every cycle is harmless: only the entry cycle can
        // change the value, so at most one update pulse results.
        delay_next = DEF_DELAY;
        if (!key_up && !key_dn) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (do_step) begin
      delay_next = step_delay(delay_reg, dir_up_reg, STEP_W);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      dir_up_reg <= 1'b1;
      cnt_reg    <= '0;
      delay_reg  <= DEF_DELAY;
      upd_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      dir_up_reg <= dir_up_next;
      cnt_reg    <= cnt_next;
      delay_reg  <= delay_next;
      // Saturated steps and no-op reloads leave delay unchanged: no pulse.
      upd_reg    <= (delay_next != delay_reg);
    end
  end

  assign bus.delay     = delay_reg;
  assign bus.delay_upd = upd_reg;

endmodule
